// File: rtl/inference_sequencer.sv
// inference_sequencer: top-level controller for one inference pass.
// Fetches hidden/output biases and output weights once, then walks the
// dataset rows: trigger hidden mmult pair, add hidden biases, form the
// output node (two truncated Q0.8 products plus output bias), write RES.
// Optional build macro: INFER_SATURATE_EN (8-bit additions clamp to max
// on carry-out instead of wrapping).
//
// Handshake: Start and mmult_done are single-cycle pulses, only acted on
// in IDLE and ROW_WAIT respectively; mmult_start, RES_write_en and Done
// are single-cycle registered pulses. Memory reads return data one cycle
// after the enable is presented.
module inference_sequencer #(
  parameter int width          = 8,
  parameter int rows           = 64,
  parameter int row_bits       = 6,
  parameter int B_depth_bits   = 4,
  parameter int C_depth_bits   = 2,
  parameter int RES_depth_bits = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Start,
  output logic                      Done,
  output logic                      mmult_start,
  output logic [row_bits-1:0]       mmult_row,
  input  logic                      mmult_done,
  input  logic [width-1:0]          hidden1_result,
  input  logic [width-1:0]          hidden2_result,
  output logic                      B_read_en,
  output logic [B_depth_bits-1:0]   B_read_address,
  input  logic [width-1:0]          B_read_data_out,
  output logic                      C_read_en,
  output logic [C_depth_bits-1:0]   C_read_address,
  input  logic [width-1:0]          C_read_data_out,
  output logic                      RES_write_en,
  output logic [RES_depth_bits-1:0] RES_write_address,
  output logic [width-1:0]          RES_write_data_in,
  output logic [2:0]                dbg_state
);

  typedef enum logic [2:0] {
    IDLE, FETCH, ROW_START, ROW_WAIT, OUT_MUL, WRITE, FINISH
  } state_t;

  state_t state, state_next;

  logic [1:0]            fcnt;
  logic [row_bits-1:0]   row;
  logic [width-1:0]      hb1, hb2, ob, ow1, ow2;
  logic [width-1:0]      h1, h2;
  logic [2*width-1:0]    prod1, prod2;
  logic [width-1:0]      p1, p2, out_sum;
  logic                  last_row;

  // 8-bit unsigned add; wraps or clamps depending on the build
  function automatic logic [width-1:0] add_w(input logic [width-1:0] a,
                                             input logic [width-1:0] b);
`ifdef INFER_SATURATE_EN
    logic [width:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[width] ? {width{1'b1}} : s[width-1:0];
`else
    return a + b;
`endif
  endfunction

  assign last_row  = (row == row_bits'(rows - 1));
  assign dbg_state = state;

  // output-node arithmetic: full products truncated to the upper byte
  always_comb begin
    prod1   = {{width{1'b0}}, h1} * {{width{1'b0}}, ow1};
    prod2   = {{width{1'b0}}, h2} * {{width{1'b0}}, ow2};
    p1      = prod1[2*width-1:width];
    p2      = prod2[2*width-1:width];
    out_sum = add_w(add_w(ob, p1), p2);
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (Start) state_next = FETCH;
      FETCH:     if (fcnt == 2'd3) state_next = ROW_START;
      ROW_START: state_next = ROW_WAIT;
      ROW_WAIT:  if (mmult_done) state_next = OUT_MUL;
      OUT_MUL:   state_next = WRITE;
      WRITE:     state_next = last_row ? FINISH : ROW_START;
      FINISH:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // datapath registers and registered outputs; pulses default low each cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt              <= '0;
      row               <= '0;
      hb1               <= '0;
      hb2               <= '0;
      ob                <= '0;
      ow1               <= '0;
      ow2               <= '0;
      h1                <= '0;
      h2                <= '0;
      Done              <= 1'b0;
      mmult_start       <= 1'b0;
      mmult_row         <= '0;
      B_read_en         <= 1'b0;
      B_read_address    <= '0;
      C_read_en         <= 1'b0;
      C_read_address    <= '0;
      RES_write_en      <= 1'b0;
      RES_write_address <= '0;
      RES_write_data_in <= '0;
    end else begin
      Done              <= 1'b0;
      mmult_start       <= 1'b0;
      B_read_en         <= 1'b0;
      B_read_address    <= '0;
      C_read_en         <= 1'b0;
      C_read_address    <= '0;
      RES_write_en      <= 1'b0;
      RES_write_address <= '0;
      RES_write_data_in <= '0;
      case (state)
        IDLE: begin
          if (Start) begin
            row       <= '0;
            fcnt      <= '0;
            B_read_en <= 1'b1;
            C_read_en <= 1'b1;
          end
        end
        FETCH: begin
          fcnt <= fcnt + 2'd1;
          case (fcnt)
            2'd0: begin
              B_read_en      <= 1'b1;
              B_read_address <= B_depth_bits'(1);
              C_read_en      <= 1'b1;
              C_read_address <= C_depth_bits'(1);
            end
            2'd1: begin
              C_read_en      <= 1'b1;
              C_read_address <= C_depth_bits'(2);
              hb1            <= B_read_data_out;
              ob             <= C_read_data_out;
            end
            2'd2: begin
              hb2 <= B_read_data_out;
              ow1 <= C_read_data_out;
            end
            default: begin
              ow2         <= C_read_data_out;
              mmult_start <= 1'b1;
              mmult_row   <= row;
            end
          endcase
        end
        ROW_WAIT: begin
          if (mmult_done) begin
            h1 <= add_w(hb1, hidden1_result);
            h2 <= add_w(hb2, hidden2_result);
          end
        end
        OUT_MUL: begin
          RES_write_en      <= 1'b1;
          RES_write_address <= RES_depth_bits'(row);
          RES_write_data_in <= out_sum;
        end
        WRITE: begin
          if (last_row) begin
            Done <= 1'b1;
          end else begin
            row         <= row + row_bits'(1);
            mmult_start <= 1'b1;
            mmult_row   <= row + row_bits'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inference_sequencer.sv
// tb_inference_sequencer: randomized scoreboard bench for inference_sequencer.
module tb_inference_sequencer;

  localparam int ROWS = 64;
  localparam int EW   = 16;
`ifdef INFER_SATURATE_EN
  localparam logic [7:0] OVF_EXP = 8'hFE;
`else
  localparam logic [7:0] OVF_EXP = 8'h0F;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT connections
  logic       start_main, extra_start, start_w;
  logic       model_done, stray_done, done_w;
  logic       Done, mmult_start, B_read_en, C_read_en, RES_write_en;
  logic [5:0] mmult_row, RES_write_address;
  logic [3:0] B_read_address;
  logic [1:0] C_read_address;
  logic [7:0] hidden1_result, hidden2_result, RES_write_data_in;
  logic [7:0] B_read_data_out = 8'h00;
  logic [7:0] C_read_data_out = 8'h00;
  logic [2:0] dbg_state;

  assign start_w = start_main | extra_start;
  assign done_w  = model_done | stray_done;

  inference_sequencer dut (
    .clk(clk), .reset(reset), .Start(start_w), .Done(Done),
    .mmult_start(mmult_start), .mmult_row(mmult_row), .mmult_done(done_w),
    .hidden1_result(hidden1_result), .hidden2_result(hidden2_result),
    .B_read_en(B_read_en), .B_read_address(B_read_address),
    .B_read_data_out(B_read_data_out),
    .C_read_en(C_read_en), .C_read_address(C_read_address),
    .C_read_data_out(C_read_data_out),
    .RES_write_en(RES_write_en), .RES_write_address(RES_write_address),
    .RES_write_data_in(RES_write_data_in), .dbg_state(dbg_state)
  );

  // memories: one-cycle read latency
  logic [7:0] b_mem [16];
  logic [7:0] c_mem [4];
  always @(posedge clk) begin
    if (B_read_en) B_read_data_out <= b_mem[B_read_address];
    if (C_read_en) C_read_data_out <= c_mem[C_read_address];
  end

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int tests = 0, fails = 0;
  int b_reads = 0, c_reads = 0, wr_count = 0, done_count = 0, mstarts = 0;
  int last_done_cyc = 0, last_wr_cyc = 0, last_wr_addr = 0;
  logic [7:0] last_wr_data = 8'h00;
  int starts_base = 0, start_cyc = 0, model_lat = 1;
  bit fixed_mode = 0, inject_start = 0;
  logic [7:0] fix_r1 = 8'h00, fix_r2 = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // reference arithmetic: 8-bit add with wrap or clamp
  function automatic int add8(input int a, input int b);
    int s;
    s = a + b;
`ifdef INFER_SATURATE_EN
    if (s > 255) s = 255;
`else
    s = s % 256;
`endif
    return s;
  endfunction

  function automatic logic [7:0] ref_out(input int hb1, input int hb2, input int ob,
                                         input int ow1, input int ow2,
                                         input int r1, input int r2);
    int h1, h2, p1, p2;
    h1 = add8(hb1, r1);
    h2 = add8(hb2, r2);
    p1 = (h1 * ow1) / 256;
    p2 = (h2 * ow2) / 256;
    return 8'(add8(add8(ob, p1), p2));
  endfunction

  // mmult model: answers each mmult_start after model_lat cycles, pushes expected write
  initial begin
    int r;
    logic [7:0] r1, r2;
    model_done = 1'b0;
    extra_start = 1'b0;
    hidden1_result = 8'h00;
    hidden2_result = 8'h00;
    forever begin
      @(negedge clk);
      if (mmult_start && !reset) begin
        r = mstarts - starts_base;
        mstarts++;
        check("mmult_row", 32'(mmult_row), 32'(r));
        if (r == 0) check("start_to_mmult_start", 32'(cyc - start_cyc), 32'd5);
        r1 = fixed_mode ? fix_r1 : 8'($urandom_range(0, 255));
        r2 = fixed_mode ? fix_r2 : 8'($urandom_range(0, 255));
        exp_q.push_back({8'(r), ref_out(b_mem[0], b_mem[1], c_mem[0], c_mem[1], c_mem[2], r1, r2)});
        @(posedge clk); #1;
        if (inject_start && r == 5) extra_start = 1'b1;
        for (int k = 1; k < model_lat; k++) begin
          @(posedge clk); #1;
          extra_start = 1'b0;
        end
        model_done = 1'b1;
        hidden1_result = r1;
        hidden2_result = r2;
        last_done_cyc = cyc;
        @(posedge clk); #1;
        model_done = 1'b0;
        extra_start = 1'b0;
        hidden1_result = 8'($urandom_range(0, 255));
        hidden2_result = 8'($urandom_range(0, 255));
      end
    end
  end

  // monitor: pops expected writes, checks write/Done timing, counts reads
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (B_read_en) b_reads++;
      if (C_read_en) c_reads++;
      if (RES_write_en) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr %0d data %0h, expected no write", RES_write_address, RES_write_data_in);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("res_addr", 32'(RES_write_address), 32'(e[15:8]));
          check("res_data", 32'(RES_write_data_in), 32'(e[7:0]));
          check("done_to_write", 32'(cyc - last_done_cyc), 32'd2);
        end
        last_wr_cyc  = cyc;
        last_wr_addr = int'(RES_write_address);
        last_wr_data = RES_write_data_in;
      end
      if (Done) begin
        done_count++;
        check("write_to_done", 32'(cyc - last_wr_cyc), 32'd1);
        check("last_row_addr", 32'(last_wr_addr), 32'(ROWS - 1));
      end
    end
  end

  task automatic check_outputs_zero(input string name);
    check(name, {Done, mmult_start, mmult_row, B_read_en, B_read_address, C_read_en,
                 C_read_address, RES_write_en, RES_write_address, RES_write_data_in}, 32'd0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    starts_base = mstarts;
    start_main = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start_main = 1'b0;
  endtask

  // one full pass; optionally a stray mmult_done in FETCH and a Start in FINISH
  task automatic run_pass(input int lat, input bit inj, input bit stray, input bit fin_start);
    int b0, c0, w0, d0, m0;
    bit got_done;
    model_lat = lat;
    inject_start = inj;
    b0 = b_reads; c0 = c_reads; w0 = wr_count; d0 = done_count;
    pulse_start();
    if (stray) stray_done = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0;
    got_done = 0;
    for (int i = 0; i < ROWS * (lat + 6) + 40; i++) begin
      @(posedge clk); #1;
      if (Done) begin got_done = 1; break; end
    end
    check("pass_done_seen", 32'(got_done), 32'd1);
    m0 = mstarts;
    if (fin_start) start_main = 1'b1;
    @(posedge clk); #1;
    start_main = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("pass_writes", 32'(wr_count - w0), 32'(ROWS));
    check("pass_b_reads", 32'(b_reads - b0), 32'd2);
    check("pass_c_reads", 32'(c_reads - c0), 32'd3);
    check("pass_done_pulses", 32'(done_count - d0), 32'd1);
    check("pass_queue_empty", 32'(exp_q.size()), 32'd0);
    check("no_start_after_done", 32'(mstarts - m0), 32'd0);
    inject_start = 0;
  endtask

  task automatic rand_mems();
    for (int i = 0; i < 16; i++) b_mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++)  c_mem[i] = 8'($urandom_range(0, 255));
  endtask

  // watchdog
  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // main sequence
  initial begin
    int w0, d0, m0, b0;
    bit hit;
    reset = 1'b1;
    start_main = 1'b0;
    stray_done = 1'b0;
    rand_mems();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_outputs");
    reset = 1'b0;

    // stray mmult_done while idle
    m0 = mstarts; w0 = wr_count; b0 = b_reads;
    @(posedge clk); #1;
    stray_done = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("idle_stray_no_start", 32'(mstarts - m0), 32'd0);
    check("idle_stray_no_write", 32'(wr_count - w0), 32'd0);
    check("idle_stray_no_read", 32'(b_reads - b0), 32'd0);
    check_outputs_zero("idle_stray_outputs");

    // basic pass with fixed values, stray done in FETCH, Start in FINISH
    b_mem[0] = 8'h10; b_mem[1] = 8'h10;
    c_mem[0] = 8'h08; c_mem[1] = 8'h80; c_mem[2] = 8'h40;
    fixed_mode = 1; fix_r1 = 8'h20; fix_r2 = 8'h40;
    run_pass(1, 0, 1, 1);
    check("basic_data", 32'(last_wr_data), 32'h34);

    // overflow corner
    b_mem[0] = 8'hF0; b_mem[1] = 8'h00;
    c_mem[0] = 8'h00; c_mem[1] = 8'hFF; c_mem[2] = 8'h00;
    fix_r1 = 8'h20; fix_r2 = 8'h00;
    run_pass(2, 0, 0, 0);
    check("overflow_data", 32'(last_wr_data), 32'(OVF_EXP));

    // random data, 3-cycle mmult, ignored Start in ROW_WAIT of row 5
    fixed_mode = 0;
    rand_mems();
    run_pass(3, 1, 0, 0);

    // reset in OUT_MUL of row 10
    rand_mems();
    model_lat = 2;
    w0 = wr_count; d0 = done_count;
    pulse_start();
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_w && (mstarts - starts_base) == 11) begin hit = 1; break; end
    end
    check("reset_row10_reached", 32'(hit), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("midpass_reset_outputs");
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("midpass_writes", 32'(wr_count - w0), 32'd10);
    check("midpass_no_done", 32'(done_count - d0), 32'd0);

    // fresh pass after reset, then random passes
    run_pass($urandom_range(1, 4), 0, 0, 0);
    for (int p = 0; p < 2; p++) begin
      rand_mems();
      run_pass($urandom_range(1, 4), 0, 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inference_sequencer.md
# inference_sequencer

Top-level controller for one inference pass over the dataset. It fetches the hidden and output bias/weight terms once, then walks the datapoints one row at a time. For each row it triggers the shared hidden-layer `mmult` pair, adds the hidden biases, computes the output node, and writes one result to RES. It sits between the AXI-stream wrapper's `Start`/`Done` handshake and the `mmult` instances plus the B, C and RES memories.

## Interface
Parameters:
- `width`, 8, data width of all memories and results (Q0.8 unsigned fixed point)
- `rows`, 64, number of datapoints (A rows) per pass
- `row_bits`, 6, width of the row index; `2**row_bits >= rows`
- `B_depth_bits`, 4, B address width
- `C_depth_bits`, 2, C address width
- `RES_depth_bits`, 6, RES address width

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `Start`  in  1  one-cycle pulse; begins a pass
- `Done`  out  1  one-cycle pulse at end of pass
- `mmult_start`  out  1  one-cycle pulse to both hidden `mmult` units
- `mmult_row`  out  row_bits  A row index for the current `mmult` run
- `mmult_done`  in  1  pulse; both hidden results valid this cycle
- `hidden1_result`, `hidden2_result`  in  width  hidden node dot products (bias excluded)
- `B_read_en`  out  1  B read enable
- `B_read_address`  out  B_depth_bits  B read address
- `B_read_data_out`  in  width  B read data, valid 1 cycle after enable
- `C_read_en`  out  1  C read enable
- `C_read_address`  out  C_depth_bits  C read address
- `C_read_data_out`  in  width  C read data, valid 1 cycle after enable
- `RES_write_en`  out  1  RES write strobe
- `RES_write_address`  out  RES_depth_bits  RES write address
- `RES_write_data_in`  out  width  RES write data

## Operation
States: IDLE, FETCH, ROW_START, ROW_WAIT, OUT_MUL, WRITE, FINISH.

- **IDLE:** waits for `Start`. On `Start`: row counter := 0, go to FETCH.
- **FETCH:** 4 cycles.
  - Cycle 0: read B[0] and C[0].
  - Cycle 1: read B[1] and C[1].
  - Cycle 2: read C[2] only.
  - Data is captured one cycle after each read into registers `hb1`, `hb2`, `ob`, `ow1`, `ow2`.
  - After the last capture, go to ROW_START.
- **ROW_START:** assert `mmult_start` for 1 cycle with `mmult_row` = row; go to ROW_WAIT.
- **ROW_WAIT:** on `mmult_done`:
  - `h1 := hb1 + hidden1_result`
  - `h2 := hb2 + hidden2_result`
  - Go to OUT_MUL.
- **OUT_MUL:** register `p1 := (h1*ow1)[15:8]` and `p2 := (h2*ow2)[15:8]`. Products are full 16-bit and truncated to the upper byte.
- **WRITE:** `RES_write_en` = 1, `RES_write_address` = row, `RES_write_data_in = ob + p1 + p2`.
  - If row == `rows-1`, go to FINISH.
  - Otherwise row++ and go to ROW_START.
- **FINISH:** `Done` = 1 for one cycle; go to IDLE.

Arithmetic: all additions are unsigned 8-bit. Overflow handling is set by the Configuration macro.

Boundary conditions:
- `Start` outside IDLE is ignored; no restart and no queueing.
- `mmult_done` outside ROW_WAIT is ignored.
- A `Start` coincident with the FINISH cycle is ignored.
- The row counter never wraps inside a pass. The last row written is `rows-1`.
- `reset` mid-pass: next cycle the block is in IDLE with all outputs 0. No further RES writes and no `Done`. Captured weights are discarded.
- `rows = 1`: exactly one row cycle, then FINISH.

## Timing
- All outputs are registered.
- Reset values: `Done`, `mmult_start`, `mmult_row`, `B_read_en`, `B_read_address`, `C_read_en`, `C_read_address`, `RES_write_en`, `RES_write_address`, `RES_write_data_in` are all 0.
- `Start` to first `mmult_start`: 5 cycles (1 IDLE→FETCH + 4 FETCH).
- `mmult_done` to `RES_write_en`: 2 cycles.
- Per-row overhead beyond `mmult` latency: 4 cycles (ROW_START, capture, OUT_MUL, WRITE).
- Last `RES_write_en` to `Done`: 1 cycle.
- Read enables are high only on the FETCH cycles that issue reads. Addresses are held at 0 otherwise.
- `RES_write_en` is high for exactly 1 cycle per row, `rows` times per pass.

## Configuration
- `INFER_SATURATE_EN` defined: every 8-bit addition (`h1`, `h2` and the output sum, applied stepwise) clamps to 255 on carry-out.
- Not defined: additions wrap modulo 256, keeping the low 8 bits.
- Multiplication truncation is identical in both builds.

## Test plan
- **Basic pass, `rows`=64:**
  - Stimulus: B[0]=B[1]=0x10, C=[0x08,0x80,0x40]; `mmult` model returns 0x20/0x40 for every row.
  - Required: 64 writes, addresses 0..63, each data = 0x08 + 0x18 + 0x14 = 0x34.
  - `Done` 1 cycle after write 63.
- **Overflow:**
  - Stimulus: hb1=0xF0, hidden1_result=0x20, ow1=0xFF, ow2=0, ob=0.
  - Required: `INFER_SATURATE_EN` gives 0xFE. Without it, h1 = 0x10 and data = 0x0F.
- **Ignored `Start`:**
  - Stimulus: pulse `Start` during ROW_WAIT of row 5.
  - Required: no extra FETCH reads; sequence continues; exactly 64 writes.
- **Reset mid-pass:**
  - Stimulus: assert `reset` in OUT_MUL of row 10.
  - Required: no write for row 10; all outputs 0 next cycle; a fresh `Start` redoes FETCH and writes row 0 first.
- **Latency check:**
  - Stimulus: `mmult` model with 3-cycle latency.
  - Required: `mmult_start` 5 cycles after `Start`; each `RES_write_en` exactly 2 cycles after `mmult_done`.
- **Stray `mmult_done`:**
  - Stimulus: pulse `mmult_done` in IDLE and in FETCH.
  - Required: no state change, no writes.
